conv_out_collector: RTL and testbench
=====================================

# conv_out_collector

Capture-side block for the 28x28 convolution engine. It receives the `conv` result stream and writes every valid 32-bit result into an internal feature-map buffer. When the frame ends, it drains the buffer in order over a valid/ready read port. It replaces bench-side file dumping of conv results and feeds the downstream pooling and FC stages.

## Interface
Parameters:
- DATA_W, 32, result word width (matches conv output_port)
- DEPTH, 576, buffer entries (24x24 valid-conv map)
- ADDR_W, 10, pointer width; must satisfy 2^ADDR_W >= DEPTH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  arm capture of one frame (pulse)
- conv_data  in  DATA_W  conv output_port
- conv_invalid  in  1  conv invalid flag; 0 = conv_data valid this cycle
- conv_finish  in  1  conv end-of-frame flag
- rd_data  out  DATA_W  buffered result
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  rd_data is the final stored entry
- count  out  ADDR_W+1  entries captured in the current/last frame
- busy  out  1  state is CAPTURE or DRAIN
- done  out  1  frame fully drained; held until next start
- overflow  out  1  sticky: a valid sample arrived with buffer full

## Operation
- States are IDLE, CAPTURE, DRAIN and DONE.
- On reset:
  - state goes to IDLE.
  - wr_ptr, rd_ptr and count go to 0.
  - rd_valid, rd_last, busy, done and overflow go to 0.
  - rd_data goes to 0.
  - Buffer contents are not cleared.
- IDLE:
  - start moves to CAPTURE and clears count and overflow.
  - conv inputs are ignored.
- CAPTURE:
  - Each cycle with conv_invalid==0 and count<DEPTH writes conv_data to buf[count] and increments count.
  - With count==DEPTH, a valid sample is dropped and overflow is set.
  - conv_finish==1 moves to DRAIN. A valid sample in the same cycle is written first.
  - The DEPTH-th write also moves to DRAIN without waiting for finish. Later samples are ignored, and overflow is not set by them.
  - start is ignored.
- DRAIN:
  - Presents buf[rd_ptr] on rd_data with rd_valid=1. rd_last=1 when rd_ptr==count-1.
  - A transfer occurs when rd_valid && rd_ready; rd_ptr then increments.
  - rd_data, rd_valid and rd_last hold stable while rd_valid && !rd_ready.
  - After the rd_last transfer, move to DONE. rd_valid and rd_last drop the next cycle.
  - If count==0 on entry, go straight to DONE with no rd_valid.
  - Conv inputs and start are ignored.
- DONE:
  - done=1.
  - start moves to CAPTURE, clears done, count, rd_ptr and overflow.
- Reset asserted in any state aborts immediately to the reset values above. Partial data is discarded logically.

## Timing
- Write: sample at edge k is in buf one edge later; count updates at edge k.
- CAPTURE to DRAIN at edge f (the finish or DEPTH-th write edge). rd_valid=1 with entry 0 from edge f+1.
- With rd_ready held high, drain is one word per cycle, DEPTH words in DEPTH cycles. No bubbles are allowed.
- done rises on the edge of the last transfer +1. busy falls on the same edge.
- start to CAPTURE is 1 cycle: a valid sample on the cycle after start is captured. A sample coincident with start is not.
- overflow, once set, holds until start in IDLE/DONE or until reset.

## Test plan
- Nominal frame:
  - Stimulus: start, then 576 valid samples of value i+1 with gaps every 3rd cycle, then finish.
  - Required response: rd stream 1..576 in order, rd_last only on 576, count=576, done=1, overflow=0.
- Early finish:
  - Stimulus: 10 samples 0xA0..0xA9, with finish coincident with the 10th.
  - Required response: 10 words drained, rd_last on 0xA9, count=10.
- Backpressure:
  - Stimulus: rd_ready toggled pseudo-randomly during drain of 50 words.
  - Required response: no loss or duplication; rd_data stable while stalled.
- Full buffer then overflow:
  - Stimulus: DEPTH=4 build; 6 consecutive valid samples with no finish; then restart with start and feed 7 valid samples with DEPTH reached on the 4th.
  - Required response: auto-DRAIN after the 4th sample; words 1..4 drained; overflow=0. On restart, overflow stays 0, because post-full samples in DRAIN are ignored.
- Empty frame:
  - Stimulus: start, then finish with no valid samples.
  - Required response: DONE next cycle, rd_valid never 1, count=0.
- Reset mid-drain:
  - Stimulus: reset high for 1 cycle after 100 of 576 words are drained.
  - Required response: all outputs at reset values next cycle; a new start plus 3 samples drains exactly those 3 words.

Source files
------------

// File: rtl/conv_out_collector.sv
// Capture buffer for the conv result stream: stores valid results during a frame,
// then drains them in order over a valid/ready port once the frame ends.
module conv_out_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 576,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] conv_data,
  input  logic              conv_invalid,
  input  logic              conv_finish,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign rd_valid = (state_q == S_DRAIN);
  assign rd_last  = rd_valid && ({1'b0, rd_ptr_q} == (count_q - ONE_C));
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign busy     = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[ADDR_W-1:0];
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CAPTURE;
          count_d    = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (!conv_invalid) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_C;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // An empty frame skips DRAIN entirely so rd_valid never pulses.
        if (conv_finish || (wr_en && (count_d == DEPTH_C))) begin
          state_d = (count_d == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_last) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_addr] <= conv_data;
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Randomized self-checking bench for conv_out_collector: a full-size instance
// and a DEPTH=4 instance, checked against a queue-based frame model.
module tb_conv_out_collector;

  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start_a, inv_a, fin_a, rdy_a;
  logic [31:0] data_a;
  logic [31:0] rd_data_a;
  logic        rd_valid_a, rd_last_a, busy_a, done_a, overflow_a;
  logic [10:0] count_a;

  logic        start_b, inv_b, fin_b, rdy_b;
  logic [31:0] data_b;
  logic [31:0] rd_data_b;
  logic        rd_valid_b, rd_last_b, busy_b, done_b, overflow_b;
  logic [2:0]  count_b;

  conv_out_collector #(.DATA_W(32), .DEPTH(576), .ADDR_W(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .conv_data(data_a),
    .conv_invalid(inv_a), .conv_finish(fin_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .rd_ready(rdy_a), .rd_last(rd_last_a),
    .count(count_a), .busy(busy_a), .done(done_a), .overflow(overflow_a)
  );

  conv_out_collector #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .conv_data(data_b),
    .conv_invalid(inv_b), .conv_finish(fin_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .rd_ready(rdy_b), .rd_last(rd_last_b),
    .count(count_b), .busy(busy_b), .done(done_b), .overflow(overflow_b)
  );

  int  checks = 0;
  int  errors = 0;
  wq_t vals;
  wq_t got;
  int  lasts[$];

  // A frame keeps the first `depth` valid samples; anything beyond is lost.
  function automatic wq_t frame_model(wq_t s, int depth);
    wq_t r;
    for (int i = 0; i < s.size() && i < depth; i++) r.push_back(s[i]);
    return r;
  endfunction

  function automatic int count_diffs(wq_t a, wq_t b);
    int n = 0;
    if (a.size() != b.size()) return 1000000;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  // Start pulse (with a coincident valid sample that must be ignored), then vals.
  // gap_mode: 0 none, 1 every 3rd cycle invalid, 2 random invalid cycles.
  task automatic feed_a(input int gap_mode, input bit fin_with_last);
    int i = 0;
    int cyc = 0;
    bit gap;
    @(negedge clk);
    start_a = 1'b1; inv_a = 1'b0; data_a = 32'hDEAD_0000 | $urandom_range(0, 255); fin_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    while (i < vals.size()) begin
      gap = (gap_mode == 1) ? (cyc % 3 == 2) : (gap_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (gap) begin
        inv_a = 1'b1; data_a = $urandom; fin_a = 1'b0;
      end else begin
        inv_a = 1'b0; data_a = vals[i];
        fin_a = fin_with_last && (i == vals.size() - 1);
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    inv_a = 1'b1; fin_a = 1'b0;
    if (!fin_with_last) begin
      fin_a = 1'b1;
      @(negedge clk);
      fin_a = 1'b0;
    end
  endtask

  // Gathers drained words; rdy_mode 0 holds ready high, 1 toggles it randomly.
  task automatic collect_a(input int rdy_mode, input int max_words,
                           output int unstable, output int bubbles, output bit timeout);
    bit          stalled = 1'b0;
    bit          rdy;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    got.delete(); lasts.delete();
    unstable = 0; bubbles = 0; timeout = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      if (done_a === 1'b1) begin timeout = 1'b0; break; end
      if (max_words > 0 && got.size() >= max_words) begin timeout = 1'b0; break; end
      if (stalled && (rd_data_a !== held_data || rd_valid_a !== 1'b1 || rd_last_a !== held_last))
        unstable++;
      if (rd_valid_a !== 1'b1) bubbles++;
      rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rdy_a = rdy;
      if (rd_valid_a === 1'b1 && rdy) begin
        got.push_back(rd_data_a);
        if (rd_last_a === 1'b1) lasts.push_back(got.size() - 1);
        stalled = 1'b0;
      end else if (rd_valid_a === 1'b1) begin
        stalled = 1'b1; held_data = rd_data_a; held_last = rd_last_a;
      end
      @(negedge clk);
    end
    rdy_a = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_valid_a, rd_last_a, busy_a, done_a, overflow_a} !== 5'b0 || count_a !== 11'd0 || rd_data_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_a: valid=%b last=%b busy=%b done=%b ovf=%b count=%0d data=%h, required all 0",
               rd_valid_a, rd_last_a, busy_a, done_a, overflow_a, count_a, rd_data_a);
    end
    checks++;
    if ({rd_valid_b, busy_b, done_b, overflow_b} !== 4'b0 || count_b !== 3'd0 || rd_data_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: valid=%b busy=%b done=%b ovf=%b count=%0d data=%h, required all 0",
               rd_valid_b, busy_b, done_b, overflow_b, count_b, rd_data_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal;
    int unstable, bubbles, d;
    bit to;
    wq_t exp;
    vals.delete();
    for (int i = 0; i < 576; i++) vals.push_back(32'(i + 1));
    exp = frame_model(vals, 576);
    feed_a(1, 1'b0);
    collect_a(0, 0, unstable, bubbles, to);
    d = count_diffs(got, exp);
    checks++;
    if (to || d != 0) begin
      errors++;
      $display("FAIL nominal_data: got %0d words, diffs=%0d timeout=%0b, required %0d words in order",
               got.size(), d, to, exp.size());
    end
    checks++;
    if (lasts.size() != 1 || lasts[0] != 575) begin
      errors++;
      $display("FAIL nominal_last: rd_last count=%0d first_idx=%0d, required one at 575",
               lasts.size(), (lasts.size() > 0) ? lasts[0] : -1);
    end
    checks++;
    if (bubbles != 0) begin
      errors++;
      $display("FAIL nominal_bubbles: %0d idle cycles with ready high, required 0", bubbles);
    end
    checks++;
    if (count_a !== 11'd576 || done_a !== 1'b1 || overflow_a !== 1'b0 || busy_a !== 1'b0 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL nominal_end: count=%0d done=%b ovf=%b busy=%b valid=%b, required 576/1/0/0/0",
               count_a, done_a, overflow_a, busy_a, rd_valid_a);
    end
  endtask

  task automatic test_early_finish;
    int unstable, bubbles, d;
    bit to;
    wq_t exp;
    vals.delete();
    for (int i = 0; i < 10; i++) vals.push_back(32'hA0 + 32'(i));
    exp = frame_model(vals, 576);
    feed_a(0, 1'b1);
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hA0) begin
      errors++;
      $display("FAIL early_first: valid=%b data=%h one cycle after finish, required 1/000000a0",
               rd_valid_a, rd_data_a);
    end
    collect_a(0, 0, unstable, bubbles, to);
    d = count_diffs(got, exp);
    checks++;
    if (to || d != 0 || lasts.size() != 1 || lasts[0] != 9) begin
      errors++;
      $display("FAIL early_data: words=%0d diffs=%0d lasts=%0d timeout=%0b, required 10 words, last on A9",
               got.size(), d, lasts.size(), to);
    end
    checks++;
    if (count_a !== 11'd10 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL early_count: count=%0d done=%b, required 10/1", count_a, done_a);
    end
  endtask

  task automatic test_backpressure;
    int unstable, bubbles, d;
    bit to;
    wq_t exp;
    vals.delete();
    for (int i = 0; i < 50; i++) vals.push_back($urandom);
    exp = frame_model(vals, 576);
    feed_a(2, 1'b0);
    collect_a(1, 0, unstable, bubbles, to);
    d = count_diffs(got, exp);
    checks++;
    if (to || d != 0) begin
      errors++;
      $display("FAIL bp_data: words=%0d diffs=%0d timeout=%0b, required 50 words in order",
               got.size(), d, to);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d stalled cycles changed outputs, required 0", unstable);
    end
    checks++;
    if (lasts.size() != 1 || lasts[0] != 49 || count_a !== 11'd50) begin
      errors++;
      $display("FAIL bp_last: lasts=%0d count=%0d, required one last at 49, count 50",
               lasts.size(), count_a);
    end
  endtask

  task automatic test_full_overflow;
    wq_t v, gb, exp;
    bool_loop: for (int round = 0; round < 2; round++) begin
      int n = (round == 0) ? 6 : 7;
      bit drained = 1'b0;
      v.delete(); gb.delete();
      @(negedge clk);
      start_b = 1'b1; inv_b = 1'b1; rdy_b = 1'b0;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < n; k++) begin
        v.push_back((round == 0) ? 32'(k + 1) : $urandom);
        inv_b = 1'b0; data_b = v[k];
        @(negedge clk);
        if (k == 3) begin
          checks++;
          if (rd_valid_b !== 1'b1 || rd_data_b !== v[0]) begin
            errors++;
            $display("FAIL full_autodrain r%0d: valid=%b data=%h after 4th sample, required 1/%h",
                     round, rd_valid_b, rd_data_b, v[0]);
          end
        end
      end
      inv_b = 1'b1;
      for (int c = 0; c < 50; c++) begin
        if (done_b === 1'b1) begin drained = 1'b1; break; end
        rdy_b = 1'b1;
        if (rd_valid_b === 1'b1) gb.push_back(rd_data_b);
        @(negedge clk);
      end
      rdy_b = 1'b0;
      exp = frame_model(v, 4);
      checks++;
      if (!drained || count_diffs(gb, exp) != 0) begin
        errors++;
        $display("FAIL full_data r%0d: words=%0d drained=%0b, required first 4 samples",
                 round, gb.size(), drained);
      end
      checks++;
      if (overflow_b !== 1'b0 || count_b !== 3'd4) begin
        errors++;
        $display("FAIL full_ovf r%0d: overflow=%b count=%0d, required 0/4", round, overflow_b, count_b);
      end
    end
  endtask

  task automatic test_empty;
    bit seen_valid = 1'b0;
    vals.delete();
    feed_a(0, 1'b0);
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 11'd0 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done=%b busy=%b count=%0d valid=%b, required 1/0/0/0",
               done_a, busy_a, count_a, rd_valid_a);
    end
    repeat (4) begin
      if (rd_valid_a !== 1'b0) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_valid || done_a !== 1'b1) begin
      errors++;
      $display("FAIL empty_quiet: rd_valid seen=%0b done=%b, required 0/1", seen_valid, done_a);
    end
  endtask

  task automatic test_reset_mid_drain;
    int unstable, bubbles, d;
    bit to;
    wq_t exp;
    vals.delete();
    for (int i = 0; i < 576; i++) vals.push_back($urandom);
    feed_a(0, 1'b0);
    collect_a(0, 100, unstable, bubbles, to);
    checks++;
    if (to || got.size() != 100 || count_diffs(got, frame_model(vals, 100)) != 0) begin
      errors++;
      $display("FAIL mid_prefix: words=%0d timeout=%0b, required first 100 words", got.size(), to);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({rd_valid_a, rd_last_a, busy_a, done_a, overflow_a} !== 5'b0 || count_a !== 11'd0 || rd_data_a !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b last=%b busy=%b done=%b ovf=%b count=%0d data=%h, required all 0",
               rd_valid_a, rd_last_a, busy_a, done_a, overflow_a, count_a, rd_data_a);
    end
    vals.delete();
    for (int i = 0; i < 3; i++) vals.push_back($urandom);
    exp = frame_model(vals, 576);
    feed_a(0, 1'b0);
    collect_a(0, 0, unstable, bubbles, to);
    d = count_diffs(got, exp);
    checks++;
    if (to || d != 0 || count_a !== 11'd3 || lasts.size() != 1 || lasts[0] != 2) begin
      errors++;
      $display("FAIL mid_restart: words=%0d diffs=%0d count=%0d lasts=%0d timeout=%0b, required 3 words, last on idx 2",
               got.size(), d, count_a, lasts.size(), to);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; inv_a = 1'b1; fin_a = 1'b0; rdy_a = 1'b0; data_a = '0;
    start_b = 1'b0; inv_b = 1'b1; fin_b = 1'b0; rdy_b = 1'b0; data_b = '0;
    test_reset();
    test_nominal();
    test_early_finish();
    test_backpressure();
    test_full_overflow();
    test_empty();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
